// File: rtl/cpu_pkg.sv
// Shared fetch-unit types: FSM state encoding and default sequential PC step.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int unsigned DEFAULT_PC_STEP = 4;

    // A redirect target must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/multicycle_fetch.sv
// Multicycle instruction fetch: one outstanding imem request, single-entry
// holding register, redirect flush handling and sticky misalignment fault.
module multicycle_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending;
    logic            pending_fault;

    logic            redirect_bad;
    logic            flush_fault;
    logic [XLEN-1:0] flush_target;
    logic            accept;

    // A redirect arriving in the same cycle as the flush ack is the newest target.
    assign redirect_bad = redirect_valid && is_misaligned(redirect_pc[1:0]);
    assign flush_fault  = pending_fault || redirect_bad;
    assign flush_target = redirect_valid ? redirect_pc : pending;
    assign accept       = (state == HOLD) && out_ready && !redirect_valid;

    // The address comes straight from the PC register, so it cannot glitch mid-request.
    assign imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= REQ;
            pc            <= RESET_PC;
            pending       <= '0;
            pending_fault <= 1'b0;
            imem_req      <= 1'b1;
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_pc        <= '0;
            fault         <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_bad) begin
                        state    <= FAULT;
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                    end else if (redirect_valid && imem_ack) begin
                        pc <= redirect_pc;
                    end else if (redirect_valid) begin
                        state         <= FLUSH;
                        pending       <= redirect_pc;
                        pending_fault <= 1'b0;
                    end else if (imem_ack) begin
                        state     <= HOLD;
                        out_instr <= imem_rdata;
                        out_pc    <= pc;
                        imem_req  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        pending <= redirect_pc;
                    end
                    if (redirect_bad) begin
                        pending_fault <= 1'b1;
                    end
                    if (imem_ack) begin
                        if (flush_fault) begin
                            state    <= FAULT;
                            imem_req <= 1'b0;
                            fault    <= 1'b1;
                        end else begin
                            state <= REQ;
                            pc    <= flush_target;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_bad) begin
                        state     <= FAULT;
                        out_valid <= 1'b0;
                        fault     <= 1'b1;
                    end else if (redirect_valid) begin
                        state     <= REQ;
                        pc        <= redirect_pc;
                        imem_req  <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        state     <= REQ;
                        pc        <= pc + XLEN'(PC_STEP);
                        imem_req  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                FAULT: begin
                    imem_req  <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_count (
        .clock(clock),
        .reset(reset),
        .clear(1'b0),
        .inc  (accept),
        .count(fetch_count)
    );

endmodule

// File: tb/tb_multicycle_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level model of the fetch unit.
module tb_multicycle_fetch;

    localparam logic [63:0] CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    logic        reset_b;
    logic        imem_req_b;
    logic [63:0] imem_addr_b;
    logic        imem_ack_b;
    logic [31:0] imem_rdata_b;
    logic        redirect_valid_b;
    logic [63:0] redirect_pc_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [31:0] out_instr_b;
    logic [63:0] out_pc_b;
    logic        fault_b;
    logic [1:0]  fetch_count_b;

    multicycle_fetch dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    multicycle_fetch #(
        .CNT_W(2),
        .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
    ) dut_b (
        .clock(clock), .reset(reset_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_instr(out_instr_b), .out_pc(out_pc_b),
        .fault(fault_b), .fetch_count(fetch_count_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a machine is dead, holding a word, flushing a
    // stale request towards a new target, or waiting on a fetch of pc.
    bit          m_dead, m_have, m_flush, m_bad;
    logic [63:0] m_pc, m_target, m_opc;
    logic [31:0] m_instr;
    logic [63:0] m_count;

    always @(posedge clock or posedge reset) begin
        logic mis;
        logic [63:0] tgt;
        if (reset) begin
            m_dead <= 0; m_have <= 0; m_flush <= 0; m_bad <= 0;
            m_pc <= 64'd0; m_target <= 64'd0; m_opc <= 64'd0;
            m_instr <= 32'd0; m_count <= 64'd0;
        end else if (!m_dead) begin
            mis = redirect_valid && (redirect_pc % 4 != 0);
            if (m_have) begin
                if (mis) begin
                    m_dead <= 1; m_have <= 0;
                end else if (redirect_valid) begin
                    m_pc <= redirect_pc; m_have <= 0;
                end else if (out_ready) begin
                    m_pc <= m_pc + 64'd4; m_have <= 0;
                    m_count <= (m_count >= CNT_MAX) ? CNT_MAX : m_count + 64'd1;
                end
            end else if (m_flush) begin
                tgt = redirect_valid ? redirect_pc : m_target;
                m_target <= tgt;
                if (mis) m_bad <= 1;
                if (imem_ack) begin
                    m_flush <= 0;
                    if (m_bad || mis) m_dead <= 1;
                    else m_pc <= tgt;
                end
            end else begin
                if (mis) begin
                    m_dead <= 1;
                end else if (redirect_valid && imem_ack) begin
                    m_pc <= redirect_pc;
                end else if (redirect_valid) begin
                    m_flush <= 1; m_target <= redirect_pc; m_bad <= 0;
                end else if (imem_ack) begin
                    m_have <= 1; m_instr <= imem_rdata; m_opc <= m_pc;
                end
            end
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("imem_req", 64'(imem_req), 64'(!m_dead && !m_have));
            if (!m_dead && !m_have) check("imem_addr", imem_addr, m_pc);
            check("out_valid", 64'(out_valid), 64'(m_have && !m_dead));
            if (m_have && !m_dead) begin
                check("out_instr", 64'(out_instr), 64'(m_instr));
                check("out_pc", out_pc, m_opc);
            end
            check("fault", 64'(fault), 64'(m_dead));
            check("fetch_count", 64'(fetch_count), m_count);
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        imem_ack = 0; imem_rdata = 32'd0; out_ready = 0;
        redirect_valid = 0; redirect_pc = 64'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    logic [63:0] seen[$];
    logic [63:0] rpc;

    initial begin
        reset = 1; reset_b = 1;
        clear_inputs();
        imem_ack_b = 0; imem_rdata_b = 32'd0; out_ready_b = 0;
        redirect_valid_b = 0; redirect_pc_b = 64'd0;

        // Reset values and slow first fetch.
        do_reset();
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_count", 64'(fetch_count), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        repeat (3) step();
        check("wait_addr", imem_addr, 64'd0);
        imem_ack = 1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 0;
        check("slow_valid", 64'(out_valid), 64'd1);
        check("slow_out_pc", out_pc, 64'd0);
        check("slow_out_instr", 64'(out_instr), 64'h0050_0093);
        check("slow_req_low", 64'(imem_req), 64'd0);
        out_ready = 1;
        step();
        out_ready = 0;
        check("slow_next_req", 64'(imem_req), 64'd1);
        check("slow_next_addr", imem_addr, 64'd4);
        check("slow_count", 64'(fetch_count), 64'd1);

        // Back-to-back fetches with immediate ack and ready.
        do_reset();
        seen.delete();
        imem_ack = 1; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) seen.push_back(imem_addr);
            imem_rdata = $urandom;
            step();
        end
        clear_inputs();
        check("b2b_nreq", 64'(seen.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) check($sformatf("b2b_addr%0d", i), seen[i], 64'(4 * i));
        end
        check("b2b_count", 64'(fetch_count), 64'd5);

        // Redirect while the request is outstanding: flush, then refetch.
        do_reset();
        redirect_valid = 1; redirect_pc = 64'h100;
        step();
        redirect_valid = 0;
        check("flush_req", 64'(imem_req), 64'd1);
        check("flush_addr0", imem_addr, 64'd0);
        step();
        check("flush_addr1", imem_addr, 64'd0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_new_addr", imem_addr, 64'h100);
        step();
        check("flush_valid2", 64'(out_valid), 64'd0);

        // Redirect beats out_ready in HOLD.
        do_reset();
        imem_ack = 1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 0;
        check("hold_valid", 64'(out_valid), 64'd1);
        redirect_valid = 1; redirect_pc = 64'h40; out_ready = 1;
        step();
        clear_inputs();
        check("prio_count", 64'(fetch_count), 64'd0);
        check("prio_addr", imem_addr, 64'h40);
        check("prio_req", 64'(imem_req), 64'd1);
        check("prio_valid", 64'(out_valid), 64'd0);

        // Misaligned redirect faults and stays faulted until reset.
        do_reset();
        redirect_valid = 1; redirect_pc = 64'h102;
        step();
        redirect_valid = 0;
        check("fault_set", 64'(fault), 64'd1);
        check("fault_req", 64'(imem_req), 64'd0);
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom); out_ready = 1'($urandom);
            redirect_valid = 1'($urandom); redirect_pc = 64'h200;
            step();
            check($sformatf("fault_sticky%0d", i), 64'(fault), 64'd1);
            check($sformatf("fault_noreq%0d", i), 64'(imem_req), 64'd0);
            check($sformatf("fault_novalid%0d", i), 64'(out_valid), 64'd0);
        end
        do_reset();
        check("fault_cleared", 64'(fault), 64'd0);
        check("fault_req_back", 64'(imem_req), 64'd1);

        // Narrow counter saturation and PC wrap on the second instance.
        @(negedge clock);
        reset_b = 0;
        seen.delete();
        imem_ack_b = 1; out_ready_b = 1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_b) seen.push_back(imem_addr_b);
            imem_rdata_b = $urandom;
            step();
        end
        imem_ack_b = 0; out_ready_b = 0;
        check("sat_nreq", 64'(seen.size()), 64'd5);
        if (seen.size() >= 2) begin
            check("wrap_addr0", seen[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_addr1", seen[1], 64'd0);
        end
        check("sat_count", 64'(fetch_count_b), 64'd3);

        // Randomized traffic checked by the model every cycle.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                imem_ack = ($urandom_range(0, 2) == 0);
                imem_rdata = $urandom;
                out_ready = 1'($urandom);
                redirect_valid = ($urandom_range(0, 9) == 0);
                rpc = {$urandom, $urandom};
                rpc[1:0] = 2'b00;
                if ($urandom_range(0, 4) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                if ($urandom_range(0, 149) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
                redirect_pc = rpc;
                step();
            end
        end
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
